// File: rtl/reg_bank_param_if.sv
// Operand/write bus for reg_bank_param: write port, two read ports, clear control and status.
interface reg_bank_param_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 16
);
    localparam int unsigned AW = $clog2(NREGS);

    logic              regwe;
    logic [DATA_W-1:0] inA;
    logic [AW-1:0]     selwreg;
    logic [1:0]        endreg;
    logic [AW-1:0]     seloutA;
    logic [AW-1:0]     seloutB;
    logic              cnstA;
    logic              cnstB;
    logic              enrregA;
    logic              enrregB;
    logic              clr;
    logic              busy;
    logic              clr_done;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;

    modport master (
        output regwe, inA, selwreg, endreg, seloutA, seloutB,
        output cnstA, cnstB, enrregA, enrregB, clr,
        input  busy, clr_done, outA, outB
    );

    modport slave (
        input  regwe, inA, selwreg, endreg, seloutA, seloutB,
        input  cnstA, cnstB, enrregA, enrregB, clr,
        output busy, clr_done, outA, outB
    );
endinterface

// File: rtl/reg_bank_param.sv
// Two-read/one-write register bank with half-word write modes, constant operands,
// optional write-through bypass and a one-register-per-cycle clear sweep.
module reg_bank_param #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 16,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    reg_bank_param_if.slave bus_io
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned H  = DATA_W / 2;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic              write_en;
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] wr_old, wr_merged;

    function automatic logic [H-1:0] const_half(input logic [1:0] code);
        logic [H-1:0] v;
        case (code)
            2'b00:   v = '0;
            2'b01:   v = H'(1);
            2'b10:   v = '1;
            default: v = {{(H-1){1'b1}}, 1'b0};
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] const_word(input logic [3:0] code);
        return {const_half(code[3:2]), const_half(code[1:0])};
    endfunction

    // Writes are dropped entirely while the sweep owns the array.
    assign write_en = bus_io.regwe && (state_q == StIdle);
    assign wr_old   = regs_q[bus_io.selwreg];

    always_comb begin
        wr_merged = bus_io.inA;
        unique case (bus_io.endreg)
            2'b00: wr_merged = bus_io.inA;
            2'b01: wr_merged = {bus_io.inA[DATA_W-1:H], wr_old[H-1:0]};
            2'b10: wr_merged = {wr_old[DATA_W-1:H], bus_io.inA[H-1:0]};
            2'b11: wr_merged = {bus_io.inA[H-1:0], bus_io.inA[DATA_W-1:H]};
            default: wr_merged = bus_io.inA;
        endcase
    end

    assign hit_a = BYPASS && write_en && !bus_io.cnstA && (bus_io.selwreg == bus_io.seloutA);
    assign hit_b = BYPASS && write_en && !bus_io.cnstB && (bus_io.selwreg == bus_io.seloutB);

    always_comb begin
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        if (bus_io.enrregA) begin
            if (bus_io.cnstA)  out_a_d = const_word(bus_io.seloutA[3:0]);
            else if (hit_a)    out_a_d = wr_merged;
            else               out_a_d = regs_q[bus_io.seloutA];
        end
        if (bus_io.enrregB) begin
            if (bus_io.cnstB)  out_b_d = const_word(bus_io.seloutB[3:0]);
            else if (hit_b)    out_b_d = wr_merged;
            else               out_b_d = regs_q[bus_io.seloutB];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        regs_d     = regs_q;
        unique case (state_q)
            StIdle: begin
                if (write_en) regs_d[bus_io.selwreg] = wr_merged;
                if (bus_io.clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d    = StIdle;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            regs_q     <= regs_d;
        end
    end

    assign bus_io.busy     = (state_q == StClear);
    assign bus_io.clr_done = clr_done_q;
    assign bus_io.outA     = out_a_q;
    assign bus_io.outB     = out_b_q;
endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench: two banks (bypass on/off) driven by identical stimulus, checked against
// hand-computed values.
module tb_reg_bank_param;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regwe = 1'b0;
    logic [63:0] in_a = '0;
    logic [3:0]  selwreg = '0;
    logic [1:0]  endreg = '0;
    logic [3:0]  sel_a = '0;
    logic [3:0]  sel_b = '0;
    logic        cnst_a = 1'b0;
    logic        cnst_b = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    reg_bank_param_if #(.DATA_W(64), .NREGS(16)) bus1 ();
    reg_bank_param_if #(.DATA_W(64), .NREGS(16)) bus0 ();

    assign bus1.regwe = regwe;    assign bus0.regwe = regwe;
    assign bus1.inA = in_a;       assign bus0.inA = in_a;
    assign bus1.selwreg = selwreg; assign bus0.selwreg = selwreg;
    assign bus1.endreg = endreg;  assign bus0.endreg = endreg;
    assign bus1.seloutA = sel_a;  assign bus0.seloutA = sel_a;
    assign bus1.seloutB = sel_b;  assign bus0.seloutB = sel_b;
    assign bus1.cnstA = cnst_a;   assign bus0.cnstA = cnst_a;
    assign bus1.cnstB = cnst_b;   assign bus0.cnstB = cnst_b;
    assign bus1.enrregA = en_a;   assign bus0.enrregA = en_a;
    assign bus1.enrregB = en_b;   assign bus0.enrregB = en_b;
    assign bus1.clr = clr;        assign bus0.clr = clr;

    reg_bank_param #(.DATA_W(64), .NREGS(16), .BYPASS(1'b1)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus1.slave)
    );

    reg_bank_param #(.DATA_W(64), .NREGS(16), .BYPASS(1'b0)) dut_nobyp (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus0.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [63:0] data,
                             input logic [1:0] mode);
        regwe = 1'b1; selwreg = addr; in_a = data; endreg = mode;
        cycle();
        regwe = 1'b0;
    endtask

    task automatic read_a(input logic [3:0] addr);
        en_a = 1'b1; cnst_a = 1'b0; sel_a = addr;
        cycle();
        en_a = 1'b0;
    endtask

    task automatic read_b(input logic [3:0] code, input logic cnst);
        en_b = 1'b1; cnst_b = cnst; sel_b = code;
        cycle();
        en_b = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;
    logic [63:0] exp_v;

    initial begin
        #1 rst = 1'b1;
        #1;
        check_eq("rst_outA", bus1.outA, 64'h0);
        check_eq("rst_outB", bus1.outB, 64'h0);
        check_eq("rst_busy", {63'h0, bus1.busy}, 64'h0);
        check_eq("rst_done", {63'h0, bus1.clr_done}, 64'h0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // regs 1..15 get 4..18, reg0 gets 19
        for (int i = 0; i < 16; i++) write_reg(4'((i + 1) % 16), 64'(4 + i), 2'b00);
        for (int k = 0; k < 16; k++) begin
            read_a(4'(k));
            exp_v = (k == 0) ? 64'd19 : 64'(k + 3);
            check_eq($sformatf("rd_reg%0d", k), bus1.outA, exp_v);
        end
        sel_a = 4'd7;
        cycle();
        check_eq("hold_outA", bus1.outA, 64'd18);

        write_reg(4'd15, 64'h0, 2'b00);
        write_reg(4'd15, 64'h0000000100000002, 2'b01);
        read_b(4'd15, 1'b0);
        check_eq("mode01", bus1.outB, 64'h0000000100000000);
        write_reg(4'd15, 64'h0000000100000002, 2'b10);
        read_b(4'd15, 1'b0);
        check_eq("mode10", bus1.outB, 64'h0000000100000002);
        write_reg(4'd15, 64'h0000000100000002, 2'b11);
        read_b(4'd15, 1'b0);
        check_eq("mode11", bus1.outB, 64'h0000000200000001);

        read_b(4'b0000, 1'b1); check_eq("cnst0000", bus1.outB, 64'h0);
        read_b(4'b1000, 1'b1); check_eq("cnst1000", bus1.outB, 64'hffffffff00000000);
        read_b(4'b0101, 1'b1); check_eq("cnst0101", bus1.outB, 64'h0000000100000001);
        read_b(4'b1111, 1'b1); check_eq("cnst1111", bus1.outB, 64'hfffffffefffffffe);
        read_b(4'b1010, 1'b1); check_eq("cnst1010", bus1.outB, 64'hffffffffffffffff);
        read_b(4'b0100, 1'b1); check_eq("cnst0100", bus1.outB, 64'h0000000100000000);

        regwe = 1'b1; selwreg = 4'd3; in_a = 64'hAA; endreg = 2'b00;
        en_a = 1'b1; cnst_a = 1'b0; sel_a = 4'd3;
        cycle();
        regwe = 1'b0; en_a = 1'b0;
        check_eq("bypass_on", bus1.outA, 64'hAA);
        check_eq("bypass_off", bus0.outA, 64'd6);
        read_a(4'd3);
        check_eq("after_byp_off", bus0.outA, 64'hAA);

        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_eq("sweep_busy_start", {63'h0, bus1.busy}, 64'h1);
        busy_cnt = 1;
        done_cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 3) begin en_a = 1'b1; cnst_a = 1'b0; sel_a = 4'd15; end
            if (k == 10) begin
                regwe = 1'b1; selwreg = 4'd5; in_a = 64'hDEAD; endreg = 2'b00; clr = 1'b1;
                en_b = 1'b1; cnst_b = 1'b0; sel_b = 4'd5;
            end
            cycle();
            en_a = 1'b0; en_b = 1'b0; regwe = 1'b0; clr = 1'b0;
            if (k == 3) check_eq("sweep_read_live", bus1.outA, 64'h0000000200000001);
            if (k == 10) check_eq("sweep_no_bypass", bus1.outB, 64'h0);
            if (k == 16) check_eq("done_at_end", {63'h0, bus1.clr_done}, 64'h1);
            if (bus1.busy) busy_cnt++;
            if (bus1.clr_done) done_cnt++;
        end
        check_eq("sweep_busy_cycles", 64'(busy_cnt), 64'd16);
        check_eq("sweep_done_pulses", 64'(done_cnt), 64'd1);
        for (int k = 0; k < 16; k++) begin
            read_a(4'(k));
            check_eq($sformatf("cleared_reg%0d", k), bus1.outA, 64'h0);
        end

        write_reg(4'd12, 64'h1234, 2'b00);
        regwe = 1'b1; selwreg = 4'd2; in_a = 64'h77; endreg = 2'b00; clr = 1'b1;
        cycle();
        regwe = 1'b0; clr = 1'b0;
        check_eq("sweep2_busy", {63'h0, bus1.busy}, 64'h1);
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) begin en_a = 1'b1; cnst_a = 1'b0; sel_a = 4'd2; end
            if (k == 3) begin en_b = 1'b1; cnst_b = 1'b1; sel_b = 4'b1010; end
            cycle();
            en_a = 1'b0; en_b = 1'b0;
            if (k == 2) check_eq("wr_then_sweep", bus1.outA, 64'h77);
        end
        check_eq("pre_reset_outB", bus1.outB, 64'hffffffffffffffff);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", {63'h0, bus1.busy}, 64'h0);
        check_eq("midrst_outA", bus1.outA, 64'h0);
        check_eq("midrst_outB", bus1.outB, 64'h0);
        cycle();
        rst = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus1.clr_done) done_cnt++;
            if (bus1.busy) busy_cnt++;
        end
        check_eq("midrst_no_done", 64'(done_cnt), 64'd0);
        check_eq("midrst_no_busy", 64'(busy_cnt), 64'd0);
        read_a(4'd12);
        check_eq("midrst_reg12", bus1.outA, 64'h0);
        read_a(4'd2);
        check_eq("midrst_reg2", bus1.outA, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
